// File: rtl/seq_timing_ctrl_pkg.sv
// Shared widths and named step constants for the sequence counter and the control logic
// that consumes its timing strobes.
package seq_timing_ctrl_pkg;

    localparam int unsigned SC_WIDTH = 4;
    localparam int unsigned T_WIDTH  = 16;

    // Named steps so control logic can write (sc_out == T3) instead of bare numbers.
    typedef enum logic [SC_WIDTH-1:0] {
        T0,  T1,  T2,  T3,  T4,  T5,  T6,  T7,
        T8,  T9,  T10, T11, T12, T13, T14, T15
    } step_t;

endpackage

// File: rtl/seq_timing_ctrl_dec_4to16.sv
// One-hot decoder with enable: o_out has bit i_sel set when i_en is high, all zero otherwise.
module dec_4to16
    import seq_timing_ctrl_pkg::*;
#(
    parameter int unsigned IN_W  = SC_WIDTH,
    parameter int unsigned OUT_W = T_WIDTH
) (
    input  logic             i_en,
    input  logic [IN_W-1:0]  i_sel,
    output logic [OUT_W-1:0] o_out
);

    always_comb begin
        o_out = '0;
        if (i_en) begin
            o_out[i_sel] = 1'b1;
        end
    end

endmodule

// File: rtl/seq_timing_ctrl.sv
// Sequence counter with start/stop flip-flop, wrap pulse and one-hot timing strobes
// for the basic computer control unit.
module seq_timing_ctrl
    import seq_timing_ctrl_pkg::*;
#(
    parameter int unsigned SC_W  = SC_WIDTH,
    parameter int unsigned T_W   = T_WIDTH,
    parameter bit          S_RST = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sc_clr,
    input  logic            sc_inc,
    input  logic            start,
    input  logic            halt,
    output logic [SC_W-1:0] sc_out,
    output logic [T_W-1:0]  t_out,
    output logic            running,
    output logic            wrap
);

    logic [SC_W-1:0] r_sc;
    logic            r_s;
    logic            r_wrap;

    // The counter still honours clr/inc on the edge that halts; it is gated by the old S.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sc   <= '0;
            r_s    <= S_RST;
            r_wrap <= 1'b0;
        end else begin
            if (halt) begin
                r_s <= 1'b0;
            end else if (start) begin
                r_s <= 1'b1;
            end

            r_wrap <= r_s && !sc_clr && sc_inc && (&r_sc);

            if (r_s) begin
                if (sc_clr) begin
                    r_sc <= '0;
                end else if (sc_inc) begin
                    r_sc <= r_sc + 1'b1;
                end
            end
        end
    end

    dec_4to16 #(
        .IN_W  (SC_W),
        .OUT_W (T_W)
    ) u_dec (
        .i_en  (r_s),
        .i_sel (r_sc),
        .o_out (t_out)
    );

    assign sc_out  = r_sc;
    assign running = r_s;
    assign wrap    = r_wrap;

endmodule

// File: tb/tb_seq_timing_ctrl.sv
// Directed and randomized checks of seq_timing_ctrl against a behavioural model of the
// counter, S flip-flop and wrap pulse.
module tb_seq_timing_ctrl;

    logic        clk;
    logic        reset;
    logic        sc_clr;
    logic        sc_inc;
    logic        start;
    logic        halt;
    logic [3:0]  sc_out;
    logic [15:0] t_out;
    logic        running;
    logic        wrap;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int m_sc   = 0;
    int m_s    = 0;
    int m_wrap = 0;

    seq_timing_ctrl #(
        .SC_W  (4),
        .T_W   (16),
        .S_RST (1'b0)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sc_clr  (sc_clr),
        .sc_inc  (sc_inc),
        .start   (start),
        .halt    (halt),
        .sc_out  (sc_out),
        .t_out   (t_out),
        .running (running),
        .wrap    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        int nw;
        if (reset) begin
            m_sc   = 0;
            m_s    = 0;
            m_wrap = 0;
        end else begin
            nw = 0;
            if (m_s == 1) begin
                if (sc_clr) begin
                    m_sc = 0;
                end else if (sc_inc) begin
                    if (m_sc == 15) nw = 1;
                    m_sc = (m_sc + 1) % 16;
                end
            end
            m_wrap = nw;
            if (halt) m_s = 0;
            else if (start) m_s = 1;
        end
    end

    always @(negedge clk) begin
        chk("sc_out", 32'(sc_out), 32'(m_sc));
        chk("running", 32'(running), 32'(m_s));
        chk("t_out", 32'(t_out), (m_s == 1) ? (32'd1 << m_sc) : 32'd0);
        chk("wrap", 32'(wrap), 32'(m_wrap));
    end

    // Apply inputs for one edge; returns one time unit after the following falling edge.
    task automatic step(input logic clr, input logic inc, input logic st, input logic hl);
        sc_clr = clr;
        sc_inc = inc;
        start  = st;
        halt   = hl;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b1;
        sc_clr = 1'b0;
        sc_inc = 1'b0;
        start  = 1'b0;
        halt   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_sc", 32'(sc_out), 32'd0);
        chk("reset_t", 32'(t_out), 32'd0);
        reset = 1'b0;

        // 1: async reset while running at sc=7
        step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (7) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("pre_reset_sc", 32'(sc_out), 32'd7);
        reset = 1'b1;
        #1;
        chk("async_reset_sc", 32'(sc_out), 32'd0);
        chk("async_reset_run", 32'(running), 32'd0);
        chk("async_reset_t", 32'(t_out), 32'd0);
        #1;
        reset = 1'b0;

        // 2: start, then count 1..3
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("start_run", 32'(running), 32'd1);
        chk("start_t", 32'(t_out), 32'h0001);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("inc1_t", 32'(t_out), 32'h0002);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("inc2_t", 32'(t_out), 32'h0004);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("inc3_sc", 32'(sc_out), 32'd3);
        chk("inc3_t", 32'(t_out), 32'h0008);

        // 3: full lap and wrap pulse
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (15) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("lap_sc15", 32'(sc_out), 32'd15);
        chk("lap_t15", 32'(t_out), 32'h8000);
        chk("lap_nowrap", 32'(wrap), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("wrap_sc", 32'(sc_out), 32'd0);
        chk("wrap_set", 32'(wrap), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("wrap_clear", 32'(wrap), 32'd0);

        // clear from 15 must not pulse wrap
        repeat (15) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("clr15_sc", 32'(sc_out), 32'd0);
        chk("clr15_wrap", 32'(wrap), 32'd0);

        // 4: clear wins over increment at sc=5
        repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("pre_clr_sc", 32'(sc_out), 32'd5);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("clr_win_sc", 32'(sc_out), 32'd0);
        chk("clr_win_t", 32'(t_out), 32'h0001);

        // 5: halt at sc=3 with inc still applies the increment, then freezes
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("halt_sc", 32'(sc_out), 32'd4);
        chk("halt_run", 32'(running), 32'd0);
        chk("halt_t", 32'(t_out), 32'd0);
        repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("frozen_sc", 32'(sc_out), 32'd4);

        // 6: halt beats start; start alone resumes from the frozen count
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("start_halt_run", 32'(running), 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("resume_run", 32'(running), 32'd1);
        chk("resume_t", 32'(t_out), 32'h0010);

        // Randomized traffic with occasional mid-cycle async reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                #2;
                reset = 1'b0;
            end
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 15) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
